// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_if
// Description : Configuration handshake bundle for clk_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_ctrl_if #(
    parameter int W = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_high,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_high,
        output cfg_ready,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Run/stop and ratio controller producing a glitch-free divided
//               clock; optional period counter under CLK_DIV_CTRL_PCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int W        = 8,
    parameter int DEF_DIV  = 4,
    parameter int DEF_HIGH = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          run_en,
    clk_div_ctrl_if.slave      cfg,
    output logic               clk_out,
    output logic               tick,
    output logic               busy
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    output logic [15:0]        period_cnt
`endif
);

    localparam logic [1:0]   c_IDLE      = 2'd0;
    localparam logic [1:0]   c_RUN       = 2'd1;
    localparam logic [1:0]   c_STOP_PEND = 2'd2;
    localparam logic [W-1:0] c_ONE       = W'(1);
    localparam logic [W-1:0] c_TWO       = W'(2);
    localparam logic [W-1:0] c_DEF_DIV   = W'(DEF_DIV);
    localparam logic [W-1:0] c_DEF_HIGH  = W'(DEF_HIGH);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_act_div;
    logic [W-1:0] r_act_high;
    logic [W-1:0] r_sh_div;
    logic [W-1:0] r_sh_high;
    logic         r_sh_full;
    logic         r_clk_out;
    logic         r_cfg_err;

    logic         w_counting;
    logic         w_tick;
    logic         w_apply;
    logic         w_accept;
    logic         w_legal;
    logic [W-1:0] w_high_nxt;
    logic [W-1:0] w_cnt_nxt;
    logic         w_clk_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:      if (run_en)  w_state_nxt = c_RUN;
            c_RUN:       if (!run_en) w_state_nxt = c_STOP_PEND;
            c_STOP_PEND: begin
                if (w_tick && !run_en) w_state_nxt = c_IDLE;
                else if (run_en)       w_state_nxt = c_RUN;
            end
            default:     w_state_nxt = c_IDLE;
        endcase
    end

    // Output / datapath decode
    always_comb begin
        w_counting = (r_state == c_RUN) || (r_state == c_STOP_PEND);
        w_tick     = w_counting && (r_cnt == (r_act_div - c_ONE));
        // Shadow drains every IDLE cycle, otherwise only at a period boundary
        w_apply    = r_sh_full && ((r_state == c_IDLE) || w_tick);
        w_high_nxt = w_apply ? r_sh_high : r_act_high;
        w_legal    = (cfg.cfg_div >= c_TWO) && (cfg.cfg_high != '0) &&
                     (cfg.cfg_high < cfg.cfg_div);
        w_accept   = cfg.cfg_valid && !r_sh_full;
        w_cnt_nxt  = '0;
        w_clk_nxt  = 1'b0;
        if (w_state_nxt == c_IDLE) begin
            w_cnt_nxt = '0;
            w_clk_nxt = 1'b0;
        end else if ((r_state == c_IDLE) || w_tick) begin
            w_cnt_nxt = '0;
            w_clk_nxt = (w_high_nxt != '0);
        end else begin
            w_cnt_nxt = r_cnt + c_ONE;
            w_clk_nxt = (w_cnt_nxt < r_act_high);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_clk_nxt;
        end
    end

    // Shadow and active ratio registers; accept and apply are mutually exclusive
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_act_div  <= c_DEF_DIV;
            r_act_high <= c_DEF_HIGH;
            r_sh_div   <= '0;
            r_sh_high  <= '0;
            r_sh_full  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_legal;
            if (w_apply) begin
                r_act_div  <= r_sh_div;
                r_act_high <= r_sh_high;
                r_sh_full  <= 1'b0;
            end else if (w_accept && w_legal) begin
                r_sh_div   <= cfg.cfg_div;
                r_sh_high  <= cfg.cfg_high;
                r_sh_full  <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_CTRL_PCNT_EN
    logic [15:0] r_pcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
        end else if ((r_state == c_IDLE) && (w_state_nxt == c_RUN)) begin
            r_pcnt <= '0;
        end else if (w_tick && (r_pcnt != 16'hFFFF)) begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    assign period_cnt = r_pcnt;
`endif

    assign clk_out       = r_clk_out;
    assign tick          = w_tick;
    assign busy          = (r_state != c_IDLE);
    assign cfg.cfg_ready = !r_sh_full;
    assign cfg.cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Directed self-checking bench for clk_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic run_en;
    logic clk_out;
    logic tick;
    logic busy;
`ifdef CLK_DIV_CTRL_PCNT_EN
    logic [15:0] period_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    clk_div_ctrl_if #(.W(8)) cfg_if ();

    clk_div_ctrl #(.W(8), .DEF_DIV(4), .DEF_HIGH(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .cfg        (cfg_if),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy)
`ifdef CLK_DIV_CTRL_PCNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge that starts a period (cnt = 0)
    task automatic run_period(input int div, input int high, input string tag);
        for (int i = 0; i < div; i++) begin
            chk({tag, "_clk"},  32'(clk_out), (i < high) ? 32'd1 : 32'd0);
            chk({tag, "_tick"}, 32'(tick),    (i == div - 1) ? 32'd1 : 32'd0);
            chk({tag, "_busy"}, 32'(busy),    32'd1);
            step();
        end
    endtask

    task automatic send_cfg(input int div, input int high);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'(div);
        cfg_if.cfg_high  = 8'(high);
    endtask

    initial begin
        rst              = 1'b0;
        run_en           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;
        step();
        step();

        chk("rst_clk_out", 32'(clk_out),          32'd0);
        chk("rst_tick",    32'(tick),             32'd0);
        chk("rst_busy",    32'(busy),             32'd0);
        chk("rst_cfg_err", 32'(cfg_if.cfg_err),   32'd0);
        chk("rst_ready",   32'(cfg_if.cfg_ready), 32'd1);
`ifdef CLK_DIV_CTRL_PCNT_EN
        chk("rst_pcnt",    32'(period_cnt),       32'd0);
`endif

        rst = 1'b1;
        step();
        step();
        chk("idle_clk",  32'(clk_out), 32'd0);
        chk("idle_busy", 32'(busy),    32'd0);

        // Default 4/1 pattern
        run_en = 1'b1;
        step();
        run_period(4, 1, "def0");
        run_period(4, 1, "def1");

        // Legal 6/3 offered mid-period
        chk("cfg_ready_pre", 32'(cfg_if.cfg_ready), 32'd1);
        step();
        send_cfg(6, 3);
        chk("mid_clk1", 32'(clk_out), 32'd0);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("cfg_ready_held", 32'(cfg_if.cfg_ready), 32'd0);
        chk("mid_clk2",       32'(clk_out),          32'd0);
        step();
        chk("mid_tick",        32'(tick),             32'd1);
        chk("cfg_ready_held2", 32'(cfg_if.cfg_ready), 32'd0);
        step();
        chk("cfg_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        run_period(6, 3, "new0");
        run_period(6, 3, "new1");

        // Illegal 1/1 and 5/5
        send_cfg(1, 1);
        step();
        chk("err1",       32'(cfg_if.cfg_err),   32'd1);
        chk("err1_ready", 32'(cfg_if.cfg_ready), 32'd1);
        send_cfg(5, 5);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("err2",       32'(cfg_if.cfg_err),   32'd1);
        step();
        chk("err_clear",  32'(cfg_if.cfg_err),   32'd0);
        chk("err_ready",  32'(cfg_if.cfg_ready), 32'd1);
        chk("err_clk3",   32'(clk_out),          32'd0);
        step();
        step();
        chk("err_tick5",  32'(tick),             32'd1);
        step();
        run_period(6, 3, "keep");

        // Stop requested at cnt = 1
        step();
        run_en = 1'b0;
        step();
        chk("stop_busy2", 32'(busy),    32'd1);
        chk("stop_clk2",  32'(clk_out), 32'd1);
        step();
        step();
        step();
        chk("stop_tick5", 32'(tick),    32'd1);
        chk("stop_busy5", 32'(busy),    32'd1);
        step();
        chk("stopped_clk",  32'(clk_out), 32'd0);
        chk("stopped_busy", 32'(busy),    32'd0);
        chk("stopped_tick", 32'(tick),    32'd0);
        step();
        chk("stopped_busy2", 32'(busy),   32'd0);

        // Drop then re-raise before the boundary
        run_en = 1'b1;
        step();
        step();
        run_en = 1'b0;
        step();
        chk("rr_clk2",  32'(clk_out), 32'd1);
        chk("rr_busy2", 32'(busy),    32'd1);
        run_en = 1'b1;
        step();
        chk("rr_clk3",  32'(clk_out), 32'd0);
        chk("rr_busy3", 32'(busy),    32'd1);
        step();
        step();
        chk("rr_tick5", 32'(tick),    32'd1);
        step();
        run_period(6, 3, "resume");

        // Async reset with a pending shadow
        send_cfg(3, 2);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("pend_clk",   32'(clk_out),          32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_clk",   32'(clk_out),          32'd0);
        chk("arst_busy",  32'(busy),             32'd0);
        chk("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("arst_tick",  32'(tick),             32'd0);
        chk("arst_err",   32'(cfg_if.cfg_err),   32'd0);
`ifdef CLK_DIV_CTRL_PCNT_EN
        chk("arst_pcnt",  32'(period_cnt),       32'd0);
`endif
        step();
        rst = 1'b1;
        step();
        run_period(4, 1, "post0");
        run_period(4, 1, "post1");
        run_period(4, 1, "post2");
`ifdef CLK_DIV_CTRL_PCNT_EN
        chk("pcnt_three", 32'(period_cnt), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
